tiger_irq_ctrl: RTL and testbench
=================================

# tiger_irq_ctrl

Interrupt controller for the Tiger processor. It collects up to N_IRQ interrupt lines from Avalon peripherals (the debug-slave IRQ, timers, UART, …) and applies per-line enable and edge/level configuration. It drives one prioritised, non-nesting interrupt request to the CPU with an ID and an acknowledge/end-of-interrupt handshake. Software configures and services it through an Avalon-MM slave on the same clock.

## Interface
- N_IRQ, 8: number of interrupt inputs, 1..32
- IDW, $clog2(N_IRQ) (min 1): width of interrupt ID
- clk  in  1  system clock; all inputs synchronous to it
- reset_n  in  1  reset, asynchronous, active-low
- irq_in  in  N_IRQ  peripheral interrupt lines, active-high
- avs_address  in  3  word address of CSR
- avs_read  in  1  CSR read strobe
- avs_write  in  1  CSR write strobe
- avs_writedata  in  32  CSR write data
- avs_readdata  out  32  CSR read data, registered
- cpu_irq  out  1  interrupt request to CPU, registered
- cpu_irq_id  out  IDW  ID of requested/in-service line, registered
- cpu_irq_ack  in  1  one-cycle CPU acknowledge of cpu_irq

## Operation
- Register map (word address, unused bits read 0):
  - 0 RAW (RO): captured pending bits.
  - 1 ENABLE (RW): per-line mask, reset 0.
  - 2 EDGE (RW): 1 = rising-edge line, 0 = level line; reset 0.
  - 3 CLEAR (WO): write-1-to-clear edge-latched RAW bits; no effect on level lines; reads 0.
  - 4 CTRL: bit0 GIE (RW, reset 0); bit1 IN_SERVICE (RO).
  - 5 ID (RO): bit31 valid (state != IDLE); [IDW-1:0] current ID.
  - 6 EOI (WO): any write ends service; reads 0.
  - 7: reserved, reads 0, writes ignored.
- RAW capture per line:
  - Level: RAW[i] <= irq_in[i] every cycle.
  - Edge: set on irq_in rising edge (previous-cycle sample 0, current 1). Cleared by a CLEAR write or by acknowledge of that ID. Set wins over a simultaneous clear.
- Active set = RAW & ENABLE. Priority: lowest index wins.
- FSM:
  - IDLE -> ASSERT when GIE && active != 0. The winner's ID is latched into cpu_irq_id; cpu_irq <= 1.
  - ASSERT -> SERVICE on cpu_irq_ack. cpu_irq <= 0; the edge RAW bit of the latched ID is cleared.
  - ASSERT -> IDLE if GIE is written 0 before ack; cpu_irq <= 0.
  - While in ASSERT, the ID stays frozen even if its source drops or a higher-priority line arrives. Software detects spurious interrupts via RAW.
  - SERVICE -> IDLE on an EOI write. GIE clear in SERVICE does not abort service.
  - EOI writes in IDLE/ASSERT are ignored. cpu_irq_ack outside ASSERT is ignored.
- Level sources must be cleared at the peripheral before EOI, otherwise they immediately re-assert.

## Timing
- Reset values: cpu_irq 0, cpu_irq_id 0, avs_readdata 0, FSM IDLE, RAW/ENABLE/EDGE/GIE 0, edge-history 0.
- Assertion latency: irq_in high at edge k → RAW set after k → cpu_irq high after edge k+1. Two cycles end to end.
- Ack sampled at edge a → cpu_irq low and state SERVICE after a.
- EOI write at edge e → IDLE after e. With a line still active, cpu_irq is high again after e+1.
- CSR read: avs_readdata valid the cycle after avs_read is sampled, fixed latency 1. No waitrequest.
- CSR writes take effect at the sampling edge. A read and write of the same register in the same cycle returns the old value.
- Asynchronous reset mid-handshake drops cpu_irq immediately. The CPU must tolerate a lost ack.

## Structure
- Package tiger_irq_pkg:
  - CSR address constants (RAW..EOI).
  - FSM state enum {IDLE, ASSERT, SERVICE}.
  - CTRL bit positions and ID valid bit position.
- Sub-module tiger_irq_prio: parameterised lowest-index priority encoder, N_IRQ in → valid + IDW out. Combinational, instantiated once.
- Everything else lives in the top module: capture, CSR, FSM.

## Test plan
- Level line 3: ENABLE=0x08, GIE=1, irq_in[3]=1 → cpu_irq high 2 cycles later, id=3. Ack → cpu_irq 0, ID reads 0x8000_0003. Drop irq_in, write EOI → ID reads 0.
- Priority: lines 5 and 2 rise in the same cycle, both enabled → id=2. After ack+EOI, with line 5 still high → id=5 two cycles after EOI.
- Edge line 0 (EDGE=1): one-cycle pulse → RAW=0x1 held. Ack clears RAW bit 0. A second pulse during SERVICE is latched and re-requests after EOI.
- Masking/GIE: pending line with ENABLE bit 0 → no cpu_irq. Write GIE=0 while in ASSERT → cpu_irq 0 next cycle, state IDLE.
- Edge set and CLEAR write on the same edge → RAW bit remains 1. Stray EOI in IDLE and ack in SERVICE → no state change.
- Assert reset_n low during SERVICE → cpu_irq, readdata, all CSRs 0 immediately. After release, no request until reconfigured.

Source files
------------

// File: rtl/tiger_irq_pkg.sv
// Shared definitions for the Tiger interrupt controller:
// CSR word addresses, CTRL/ID bit positions and the FSM state type.
package tiger_irq_pkg;

    localparam logic [2:0] ADDR_RAW    = 3'd0;
    localparam logic [2:0] ADDR_ENABLE = 3'd1;
    localparam logic [2:0] ADDR_EDGE   = 3'd2;
    localparam logic [2:0] ADDR_CLEAR  = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_ID     = 3'd5;
    localparam logic [2:0] ADDR_EOI    = 3'd6;

    localparam int CTRL_GIE   = 0;
    localparam int CTRL_INSVC = 1;
    localparam int ID_VALID   = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/tiger_irq_prio.sv
// Lowest-index-wins priority encoder (combinational).
// Ports: req_i (request vector), valid_o (any request), id_o (winner index).
module tiger_irq_prio
    import tiger_irq_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int IDW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] req_i,
    output logic             valid_o,
    output logic [IDW-1:0]   id_o
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                id_o    = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/tiger_irq_ctrl.sv
// Tiger interrupt controller: per-line capture (level/edge), enable mask,
// lowest-index priority, non-nesting request/ack/EOI handshake, Avalon-MM CSRs.
// Ports: clk, reset_n (async, active-low), irq_in (peripheral lines),
//   avs_* (CSR slave, read latency 1), cpu_irq/cpu_irq_id/cpu_irq_ack (CPU side).
module tiger_irq_ctrl
    import tiger_irq_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int IDW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             cpu_irq,
    output logic [IDW-1:0]   cpu_irq_id,
    input  logic             cpu_irq_ack
);

    logic [N_IRQ-1:0] raw_q, raw_d;
    logic [N_IRQ-1:0] enable_q;
    logic [N_IRQ-1:0] edge_q;
    logic [N_IRQ-1:0] prev_q;
    logic             gie_q;
    irq_state_e       state_q, state_d;
    logic             irq_q, irq_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [N_IRQ-1:0] wdata_n;
    logic [N_IRQ-1:0] clr_mask;
    logic [N_IRQ-1:0] ack_mask;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] active;
    logic             win_valid;
    logic [IDW-1:0]   win_id;
    logic             wr_enable, wr_edge, wr_clear;
    logic             wr_ctrl, wr_eoi;
    logic             ack_fire;
    logic             gie_off_wr;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata;
    assign wdata_n      = avs_writedata[N_IRQ-1:0];

    assign wr_enable = avs_write && (avs_address == ADDR_ENABLE);
    assign wr_edge   = avs_write && (avs_address == ADDR_EDGE);
    assign wr_clear  = avs_write && (avs_address == ADDR_CLEAR);
    assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_eoi    = avs_write && (avs_address == ADDR_EOI);

    assign gie_off_wr = wr_ctrl && !avs_writedata[CTRL_GIE];
    assign ack_fire   = (state_q == ST_ASSERT) && cpu_irq_ack;

    assign clr_mask = wr_clear ? wdata_n : '0;
    assign ack_mask = ack_fire ? (N_IRQ'(1) << id_q) : '0;
    assign rise     = irq_in & ~prev_q;

    // Edge lines: a new rising edge wins over any clear in the same cycle.
    assign raw_d = (edge_q & (rise | (raw_q & ~(clr_mask | ack_mask))))
                 | (~edge_q & irq_in);

    assign active = raw_q & enable_q;

    tiger_irq_prio #(
        .N_IRQ (N_IRQ),
        .IDW   (IDW)
    ) u_prio (
        .req_i   (active),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    // ID is latched only on entry to ASSERT and then frozen until the
    // next request, so a dropping or pre-empting line cannot change it.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gie_q && win_valid) begin
                    state_d = ST_ASSERT;
                    id_d    = win_id;
                end
            end
            ST_ASSERT: begin
                if (cpu_irq_ack) begin
                    state_d = ST_SERVICE;
                end else if (gie_off_wr) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        irq_d = (state_d == ST_ASSERT);
    end

    // Read data reflects pre-edge register values; held between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            unique case (avs_address)
                ADDR_RAW:    rdata_d = 32'(raw_q);
                ADDR_ENABLE: rdata_d = 32'(enable_q);
                ADDR_EDGE:   rdata_d = 32'(edge_q);
                ADDR_CTRL: begin
                    rdata_d[CTRL_GIE]   = gie_q;
                    rdata_d[CTRL_INSVC] = (state_q == ST_SERVICE);
                end
                ADDR_ID: begin
                    if (state_q != ST_IDLE) begin
                        rdata_d[ID_VALID] = 1'b1;
                        rdata_d[IDW-1:0]  = id_q;
                    end
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_q    <= '0;
            enable_q <= '0;
            edge_q   <= '0;
            prev_q   <= '0;
            gie_q    <= 1'b0;
            state_q  <= ST_IDLE;
            irq_q    <= 1'b0;
            id_q     <= '0;
            rdata_q  <= '0;
        end else begin
            raw_q   <= raw_d;
            prev_q  <= irq_in;
            state_q <= state_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            if (wr_enable) begin
                enable_q <= wdata_n;
            end
            if (wr_edge) begin
                edge_q <= wdata_n;
            end
            if (wr_ctrl) begin
                gie_q <= avs_writedata[CTRL_GIE];
            end
        end
    end

    assign avs_readdata = rdata_q;
    assign cpu_irq      = irq_q;
    assign cpu_irq_id   = id_q;

endmodule

// File: tb/tb_tiger_irq_ctrl.sv
// Directed table-driven bench for tiger_irq_ctrl (N_IRQ=8): one row per
// clock, outputs sampled 1 time unit after the rising edge.
module tb_tiger_irq_ctrl;

    localparam logic [2:0] A_RAW = 3'd0;
    localparam logic [2:0] A_EN  = 3'd1;
    localparam logic [2:0] A_EDG = 3'd2;
    localparam logic [2:0] A_CLR = 3'd3;
    localparam logic [2:0] A_CTL = 3'd4;
    localparam logic [2:0] A_ID  = 3'd5;
    localparam logic [2:0] A_EOI = 3'd6;

    typedef struct {
        logic [7:0]  irq;
        logic [2:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
        logic        ack;
        logic        eirq;
        logic [2:0]  eid;
        logic        chk;
        logic [31:0] erd;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [7:0]  irq_in;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        cpu_irq;
    logic [2:0]  cpu_irq_id;
    logic        cpu_irq_ack;

    int n_vec = 0;
    int n_bad = 0;
    vec_t q[$];

    tiger_irq_ctrl #(.N_IRQ(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .irq_in        (irq_in),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .cpu_irq       (cpu_irq),
        .cpu_irq_id    (cpu_irq_id),
        .cpu_irq_ack   (cpu_irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [7:0] irq, logic [2:0] addr,
                                logic rd, logic wr, logic [31:0] wd,
                                logic ack, logic eirq, logic [2:0] eid,
                                logic chk, logic [31:0] erd);
        vec_t v;
        v.irq = irq; v.addr = addr; v.rd = rd; v.wr = wr; v.wd = wd;
        v.ack = ack; v.eirq = eirq; v.eid = eid; v.chk = chk; v.erd = erd;
        return v;
    endfunction

    // idle / write / read / ack row shorthands
    function automatic vec_t N(logic [7:0] i, logic e, logic [2:0] id);
        return mk(i, 3'd0, 0, 0, 0, 0, e, id, 0, 0);
    endfunction
    function automatic vec_t W(logic [7:0] i, logic [2:0] a, logic [31:0] d,
                               logic e, logic [2:0] id);
        return mk(i, a, 0, 1, d, 0, e, id, 0, 0);
    endfunction
    function automatic vec_t R(logic [7:0] i, logic [2:0] a, logic [31:0] x,
                               logic e, logic [2:0] id);
        return mk(i, a, 1, 0, 0, 0, e, id, 1, x);
    endfunction
    function automatic vec_t K(logic [7:0] i, logic e, logic [2:0] id);
        return mk(i, 3'd0, 0, 0, 0, 1, e, id, 0, 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic run_q(input string tag);
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            irq_in        = q[k].irq;
            avs_address   = q[k].addr;
            avs_read      = q[k].rd;
            avs_write     = q[k].wr;
            avs_writedata = q[k].wd;
            cpu_irq_ack   = q[k].ack;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].irq", tag, k), 32'(cpu_irq), 32'(q[k].eirq));
            if (q[k].eirq)
                chk($sformatf("%s[%0d].id", tag, k), 32'(cpu_irq_id), 32'(q[k].eid));
            if (q[k].chk)
                chk($sformatf("%s[%0d].rd", tag, k), avs_readdata, q[k].erd);
        end
        @(negedge clk);
        avs_read    = 1'b0;
        avs_write   = 1'b0;
        cpu_irq_ack = 1'b0;
        q.delete();
    endtask

    initial begin
        reset_n       = 1'b0;
        irq_in        = '0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        cpu_irq_ack   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.irq", 32'(cpu_irq), 0);
        chk("rst.id", 32'(cpu_irq_id), 0);
        chk("rst.rd", avs_readdata, 0);
        reset_n = 1'b1;

        // level line 3
        q.push_back(W(8'h00, A_EN, 32'h08, 0, 0));
        q.push_back(W(8'h00, A_CTL, 32'h1, 0, 0));
        q.push_back(N(8'h08, 0, 0));
        q.push_back(N(8'h08, 1, 3));
        q.push_back(R(8'h08, A_RAW, 32'h08, 1, 3));
        q.push_back(K(8'h08, 0, 0));
        q.push_back(R(8'h08, A_ID, 32'h8000_0003, 0, 0));
        q.push_back(R(8'h00, A_CTL, 32'h3, 0, 0));
        q.push_back(W(8'h00, A_EOI, 32'h0, 0, 0));
        q.push_back(R(8'h00, A_ID, 32'h0, 0, 0));
        q.push_back(N(8'h00, 0, 0));
        // priority 2 over 5, then 5 after EOI
        q.push_back(W(8'h00, A_EN, 32'h24, 0, 0));
        q.push_back(N(8'h24, 0, 0));
        q.push_back(N(8'h24, 1, 2));
        q.push_back(K(8'h24, 0, 0));
        q.push_back(W(8'h20, A_EOI, 32'h0, 0, 0));
        q.push_back(N(8'h20, 1, 5));
        q.push_back(K(8'h20, 0, 0));
        q.push_back(W(8'h00, A_EOI, 32'h0, 0, 0));
        q.push_back(N(8'h00, 0, 0));
        // edge line 0
        q.push_back(W(8'h00, A_EDG, 32'h01, 0, 0));
        q.push_back(W(8'h00, A_EN, 32'h01, 0, 0));
        q.push_back(N(8'h01, 0, 0));
        q.push_back(R(8'h00, A_RAW, 32'h01, 1, 0));
        q.push_back(R(8'h00, A_RAW, 32'h01, 1, 0));
        q.push_back(K(8'h00, 0, 0));
        q.push_back(R(8'h00, A_RAW, 32'h00, 0, 0));
        q.push_back(N(8'h01, 0, 0));
        q.push_back(R(8'h00, A_RAW, 32'h01, 0, 0));
        q.push_back(W(8'h00, A_EOI, 32'h0, 0, 0));
        q.push_back(N(8'h00, 1, 0));
        q.push_back(K(8'h00, 0, 0));
        q.push_back(W(8'h00, A_EOI, 32'h0, 0, 0));
        q.push_back(N(8'h00, 0, 0));
        // masked line 1, then GIE drop while asserting
        q.push_back(N(8'h02, 0, 0));
        q.push_back(R(8'h02, A_RAW, 32'h02, 0, 0));
        q.push_back(N(8'h02, 0, 0));
        q.push_back(W(8'h02, A_EN, 32'h02, 0, 0));
        q.push_back(N(8'h02, 1, 1));
        q.push_back(W(8'h02, A_CTL, 32'h0, 0, 0));
        q.push_back(R(8'h02, A_CTL, 32'h0, 0, 0));
        q.push_back(R(8'h02, A_ID, 32'h0, 0, 0));
        q.push_back(N(8'h00, 0, 0));
        // edge set beats CLEAR; stray EOI; stray ack in SERVICE
        q.push_back(W(8'h01, A_CLR, 32'h01, 0, 0));
        q.push_back(R(8'h00, A_RAW, 32'h01, 0, 0));
        q.push_back(W(8'h00, A_CLR, 32'h01, 0, 0));
        q.push_back(R(8'h00, A_RAW, 32'h00, 0, 0));
        q.push_back(W(8'h00, A_EOI, 32'h0, 0, 0));
        q.push_back(R(8'h00, A_CTL, 32'h0, 0, 0));
        q.push_back(W(8'h02, A_CTL, 32'h1, 0, 0));
        q.push_back(N(8'h02, 1, 1));
        q.push_back(K(8'h02, 0, 0));
        q.push_back(mk(8'h00, A_CTL, 1, 0, 0, 1, 0, 0, 1, 32'h3));
        q.push_back(K(8'h00, 0, 0));
        q.push_back(R(8'h00, A_ID, 32'h8000_0001, 0, 0));
        run_q("main");

        // async reset during SERVICE
        reset_n = 1'b0;
        #1;
        chk("rstsvc.irq", 32'(cpu_irq), 0);
        chk("rstsvc.id", 32'(cpu_irq_id), 0);
        chk("rstsvc.rd", avs_readdata, 0);
        @(negedge clk);
        reset_n = 1'b1;

        q.push_back(R(8'h02, A_EN, 32'h0, 0, 0));
        q.push_back(R(8'h02, A_EDG, 32'h0, 0, 0));
        q.push_back(R(8'h02, A_CTL, 32'h0, 0, 0));
        q.push_back(N(8'h02, 0, 0));
        q.push_back(W(8'h02, A_EN, 32'h02, 0, 0));
        q.push_back(N(8'h02, 0, 0));
        q.push_back(W(8'h02, A_CTL, 32'h1, 0, 0));
        q.push_back(N(8'h02, 1, 1));
        run_q("post");

        // async reset while cpu_irq is high
        chk("pre.irq", 32'(cpu_irq), 1);
        reset_n = 1'b0;
        #1;
        chk("rstas.irq", 32'(cpu_irq), 0);
        chk("rstas.id", 32'(cpu_irq_id), 0);
        @(negedge clk);
        reset_n = 1'b1;
        q.push_back(N(8'h02, 0, 0));
        q.push_back(N(8'h02, 0, 0));
        q.push_back(R(8'h02, A_ID, 32'h0, 0, 0));
        run_q("fin");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
